// File: rtl/instr_mem_responder.sv
// Instruction memory responder: synchronous-read word store feeding a 2-deep in-order response buffer.
// Define IMEM_FAULT_CHECK_EN to flag misaligned or out-of-range fetches instead of wrapping the address.
module instr_mem_responder #(
    parameter int DEPTH = 256,
    parameter int AW    = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [AW-1:0]            req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_instr,
    output logic                     rsp_err,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [31:0]              prog_data
);
    localparam int IW     = $clog2(DEPTH);
    localparam int DATA_W = 32;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] buf_instr_p1 [2];
    logic [IW-1:0]     idx;
    logic              acc;
    logic              dlv;
    logic              fault;
    logic [1:0]        occ_p1;
    logic              wr_ptr_p1;
    logic              rd_ptr_p1;

    assign idx       = req_addr[2 +: IW];
    assign req_ready = reset && (occ_p1 != 2'd2);
    assign rsp_valid = (occ_p1 != 2'd0);
    assign acc       = req_valid && req_ready;
    assign dlv       = rsp_valid && rsp_ready;

`ifdef IMEM_FAULT_CHECK_EN
    logic buf_err_p1 [2];

    assign fault = (req_addr[1:0] != 2'b00) || ((req_addr >> (IW + 2)) != '0);

    always_ff @(posedge clk) begin
        if (acc) begin
            buf_err_p1[wr_ptr_p1] <= fault;
        end
    end

    assign rsp_err = rsp_valid && buf_err_p1[rd_ptr_p1];
`else
    logic unused_addr;

    assign unused_addr = ^{req_addr[1:0], req_addr >> (IW + 2)};
    assign fault       = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Read stage: the word lands directly in the response slot chosen by the write pointer,
    // so a same-edge program write is not visible to this fetch.
    always_ff @(posedge clk) begin
        if (acc) begin
            buf_instr_p1[wr_ptr_p1] <= fault ? '0 : mem[idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_p1    <= 2'd0;
            wr_ptr_p1 <= 1'b0;
            rd_ptr_p1 <= 1'b0;
        end else begin
            if (acc) begin
                wr_ptr_p1 <= ~wr_ptr_p1;
            end
            if (dlv) begin
                rd_ptr_p1 <= ~rd_ptr_p1;
            end
            case ({acc, dlv})
                2'b10:   occ_p1 <= occ_p1 + 2'd1;
                2'b01:   occ_p1 <= occ_p1 - 2'd1;
                default: occ_p1 <= occ_p1;
            endcase
        end
    end

    assign rsp_instr = rsp_valid ? buf_instr_p1[rd_ptr_p1] : '0;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomized bench for instr_mem_responder against a queue-based model of the fetch/response behaviour.
module tb_instr_mem_responder;
    localparam int DEPTH = 256;
    localparam int AW    = 64;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic        prog_we   = 1'b0;
    logic [63:0] req_addr  = '0;
    logic [7:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_instr;

    int checks = 0;
    int errors = 0;

    logic [31:0] mmem [DEPTH];
    logic [32:0] q [$];
    bit          in_rst = 1'b1;

    instr_mem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_err   (rsp_err),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Response the model owes for a fetch of byte address a, given current memory contents.
    function automatic logic [32:0] expect_rsp(input logic [63:0] a);
        int unsigned word;
        word = int'((a / 4) % DEPTH);
`ifdef IMEM_FAULT_CHECK_EN
        if ((a % 4) != 0 || a >= 4 * DEPTH) return {1'b1, 32'h0};
`endif
        return {1'b0, mmem[word]};
    endfunction

    task automatic check_outputs();
        chk("req_ready", req_ready, (!in_rst && q.size() < 2));
        chk("rsp_valid", rsp_valid, (q.size() > 0));
        if (q.size() > 0) begin
            chk("rsp_instr", rsp_instr, q[0][31:0]);
            chk("rsp_err", rsp_err, q[0][32]);
        end else if (in_rst) begin
            chk("rst_rsp_instr", rsp_instr, 0);
            chk("rst_rsp_err", rsp_err, 0);
        end
    endtask

    // Called at a falling edge: drive inputs, advance the model over the next rising edge, then check.
    task automatic cycle(input bit rst_n, input bit rv, input logic [63:0] ra, input bit rr,
                         input bit pw, input logic [7:0] pa, input logic [31:0] pd);
        bit ready_m;
        bit acc;
        bit dlv;
        reset     = rst_n;
        req_valid = rv;
        req_addr  = ra;
        rsp_ready = rr;
        prog_we   = pw;
        prog_addr = pa;
        prog_data = pd;
        if (!rst_n) begin
            in_rst = 1'b1;
            q.delete();
        end else begin
            in_rst = 1'b0;
        end
        ready_m = !in_rst && (q.size() < 2);
        acc     = rv && ready_m;
        dlv     = (q.size() > 0) && rr;
        if (dlv) void'(q.pop_front());
        if (acc) q.push_back(expect_rsp(ra));
        if (pw) mmem[pa] = pd;
        if (!rst_n) begin
            #1;
            chk("rsp_valid_async_rst", rsp_valid, 0);
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        logic [31:0] w;
        logic [63:0] a;
        bit          rn;
        int          sel;

        @(negedge clk);
        check_outputs();
        chk("rst_req_ready_lit", req_ready, 0);
        chk("rst_rsp_instr_lit", rsp_instr, 0);

        cycle(1, 0, 0, 0, 0, 0, 0);
        chk("ready_after_release", req_ready, 1);

        for (int i = 0; i < DEPTH; i++) begin
            case (i)
                0:       w = 32'h8B020020;
                1:       w = 32'hB4000040;
                2:       w = 32'hCAFE0002;
                3:       w = 32'h11223344;
                default: w = $urandom;
            endcase
            cycle(1, 0, 0, 0, 1, i[7:0], w);
        end

        // Back-to-back fetches with the consumer always ready
        cycle(1, 1, 64'd0, 1, 0, 0, 0);
        chk("b2b_first_instr", rsp_instr, 32'h8B020020);
        chk("b2b_first_err", rsp_err, 0);
        chk("b2b_ready1", req_ready, 1);
        cycle(1, 1, 64'd4, 1, 0, 0, 0);
        chk("b2b_second_instr", rsp_instr, 32'hB4000040);
        chk("b2b_ready2", req_ready, 1);
        cycle(1, 0, 0, 1, 0, 0, 0);
        chk("b2b_drained", rsp_valid, 0);

        // Backpressure: third request waits for a delivery
        cycle(1, 1, 64'd0, 0, 0, 0, 0);
        cycle(1, 1, 64'd4, 0, 0, 0, 0);
        chk("bp_full_ready", req_ready, 0);
        cycle(1, 1, 64'd8, 0, 0, 0, 0);
        chk("bp_still_full", req_ready, 0);
        chk("bp_stable_instr", rsp_instr, 32'h8B020020);
        cycle(1, 1, 64'd8, 1, 0, 0, 0);
        chk("bp_second_instr", rsp_instr, 32'hB4000040);
        chk("bp_ready_again", req_ready, 1);
        cycle(1, 1, 64'd8, 1, 0, 0, 0);
        chk("bp_third_instr", rsp_instr, 32'hCAFE0002);
        cycle(1, 0, 0, 1, 0, 0, 0);
        chk("bp_drained", rsp_valid, 0);

        // Same-edge program write returns old contents
        cycle(1, 1, 64'd12, 1, 1, 8'd3, 32'hDEADBEEF);
        chk("wr_same_edge_old", rsp_instr, 32'h11223344);
        cycle(1, 1, 64'd12, 1, 0, 0, 0);
        chk("wr_next_new", rsp_instr, 32'hDEADBEEF);
        cycle(1, 0, 0, 1, 0, 0, 0);

        // Misaligned and out-of-range fetches
        cycle(1, 1, 64'd6, 1, 0, 0, 0);
`ifdef IMEM_FAULT_CHECK_EN
        chk("misalign_err", rsp_err, 1);
        chk("misalign_instr", rsp_instr, 0);
`else
        chk("misalign_err", rsp_err, 0);
        chk("misalign_instr", rsp_instr, 32'hB4000040);
`endif
        cycle(1, 1, 64'd1024, 1, 0, 0, 0);
`ifdef IMEM_FAULT_CHECK_EN
        chk("oor_err", rsp_err, 1);
        chk("oor_instr", rsp_instr, 0);
`else
        chk("wrap_err", rsp_err, 0);
        chk("wrap_instr", rsp_instr, 32'h8B020020);
`endif
        cycle(1, 0, 0, 1, 0, 0, 0);

        // Reset mid-stream with two responses queued
        cycle(1, 1, 64'd0, 0, 0, 0, 0);
        cycle(1, 1, 64'd4, 0, 0, 0, 0);
        chk("pre_rst_valid", rsp_valid, 1);
        chk("pre_rst_ready", req_ready, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        chk("in_rst_ready", req_ready, 0);
        chk("in_rst_instr", rsp_instr, 0);
        cycle(1, 0, 0, 1, 0, 0, 0);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_no_stale", rsp_valid, 0);

        for (int n = 0; n < 3000; n++) begin
            rn  = ($urandom_range(0, 99) != 0);
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       a = {$urandom, $urandom};
                1:       a = 64'($urandom_range(0, 4 * DEPTH - 1));
                2:       a = 64'(4 * DEPTH) + 64'($urandom_range(0, 4095));
                default: a = 64'($urandom_range(0, DEPTH - 1)) * 64'd4;
            endcase
            cycle(rn, $urandom_range(0, 3) != 0, a, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 4) == 0, 8'($urandom_range(0, 255)), $urandom);
        end

        for (int n = 0; n < 4; n++) begin
            cycle(1, 0, 0, 1, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
